// File: rtl/conv_nto8_fifo.sv
// Buffered N-to-8 Tx serialiser: parallel words (32/16/8 bits per PCLK mode) queue in a
// small FIFO and leave LSB-first as one symbol per clock, with K28.5 idle fill.
module conv_nto8_fifo #(
   parameter int unsigned        IN_W       = 32,
   parameter int unsigned        OUT_W      = 8,
   parameter int unsigned        FIFO_DEPTH = 4,
   parameter logic [OUT_W-1:0]   IDLE_SYM   = 8'hBC
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     ENB,
   input  logic [1:0]               PCLK,
   input  logic [IN_W-1:0]          in,
   input  logic [IN_W/OUT_W-1:0]    K_in,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [OUT_W-1:0]         out,
   output logic                     K_out,
   output logic                     out_valid
);

   localparam int unsigned NB = IN_W / OUT_W;
   localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
   localparam int unsigned PW = $clog2(FIFO_DEPTH);

   typedef enum logic {S_IDLE, S_SEND} state_t;
   state_t state;

   logic [IN_W-1:0] mem_d [FIFO_DEPTH];
   logic [NB-1:0]   mem_k [FIFO_DEPTH];
   logic [1:0]      mem_m [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [PW:0]     count;
   logic            full, empty, push, pop;

   logic [IN_W-1:0]  w_data;
   logic [NB-1:0]    w_k;
   logic [1:0]       w_mode;
   logic [IW-1:0]    idx;
   logic [OUT_W-1:0] cur_sym;
   logic             cur_k;
   logic             last;

   // Index of the final byte for a latched width mode; modes 10 and 11 carry one byte.
   function automatic logic [IW-1:0] last_idx(input logic [1:0] m);
      case (m)
         2'b00:   last_idx = IW'(NB - 1);
         2'b01:   last_idx = IW'((NB > 1) ? (NB / 2 - 1) : 0);
         default: last_idx = '0;
      endcase
   endfunction

   assign full     = (count == (PW+1)'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign in_ready = ENB & ~full & ~RESET;
   assign push     = in_valid & in_ready;

   always_comb begin
      cur_sym = '0;
      cur_k   = 1'b0;
      for (int unsigned b = 0; b < NB; b++) begin
         if (idx == IW'(b)) begin
            cur_sym = w_data[b*OUT_W +: OUT_W];
            cur_k   = w_k[b];
         end
      end
      last = (idx == last_idx(w_mode));
      pop  = 1'b0;
      if (ENB && !empty)
         pop = (state == S_IDLE) || last;
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         mem_d[wr_ptr] <= in;
         mem_k[wr_ptr] <= K_in;
         mem_m[wr_ptr] <= PCLK;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // The last byte of a word and the load of its successor share one edge, so back-to-back words have no gap.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= S_IDLE;
         idx       <= '0;
         w_data    <= '0;
         w_k       <= '0;
         w_mode    <= '0;
         out       <= IDLE_SYM;
         K_out     <= 1'b1;
         out_valid <= 1'b0;
      end else if (!ENB) begin
         out       <= IDLE_SYM;
         K_out     <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         if (state == S_SEND) begin
            out       <= cur_sym;
            K_out     <= cur_k;
            out_valid <= 1'b1;
            if (last) begin
               idx <= '0;
               if (!pop)
                  state <= S_IDLE;
            end else begin
               idx <= idx + 1'b1;
            end
         end else begin
            out       <= IDLE_SYM;
            K_out     <= 1'b1;
            out_valid <= 1'b0;
            if (pop) begin
               state <= S_SEND;
               idx   <= '0;
            end
         end
         if (pop) begin
            w_data <= mem_d[rd_ptr];
            w_k    <= mem_k[rd_ptr];
            w_mode <= mem_m[rd_ptr];
         end
      end
   end

endmodule
